// File: rtl/not_gate_bist_pkg.sv
// Shared types and helpers for the NOT-gate BIST engine.
// No logic; compile-time constants only.
// Not applicable: no datapath flow control lives here.
package not_gate_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int STATE_W = 2;

  // All-ones marker for "no failing vector"; sliced to the index width by users.
  localparam logic [31:0] NO_ERR_IDX = '1;

  // Vector index width: max(1, clog2(n)).
  function automatic int idx_width(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/bist_sat_counter.sv
// Saturating up-counter with synchronous clear and increment enable.
// Latency: count updates one cycle after i_inc/i_clr; clear beats increment.
// No backpressure: increments arriving at full scale are dropped.
module bist_sat_counter
  import not_gate_bist_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  // Count up on enable, stick at all-ones, clear on request or reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/not_gate_bist.sv
// BIST engine for a NOT gate: toggles dut_a, waits SETTLE_CYC, checks dut_y == ~dut_a.
// Latency: done rises NUM_VECTORS*(SETTLE_CYC+1) cycles after the start-accepting edge.
// No backpressure: start is only accepted in IDLE/DONE; optional BIST_ABORT_ON_ERR_EN stops at first mismatch.
module not_gate_bist
  import not_gate_bist_pkg::*;
#(
  parameter  int NUM_VECTORS = 8,
  parameter  int SETTLE_CYC  = 1,
  parameter  int CNT_W       = 8,
  localparam int IDX_W       = idx_width(NUM_VECTORS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             dut_a,
  input  logic             dut_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [IDX_W-1:0] first_err_idx
);

  localparam int              SC_W        = idx_width(SETTLE_CYC);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_VECTORS - 1);
  localparam logic [SC_W-1:0]  SETTLE_LAST = SC_W'(SETTLE_CYC - 1);
  localparam logic [IDX_W-1:0] NONE_IDX    = NO_ERR_IDX[IDX_W-1:0];

  state_e           r_state;
  state_e           w_state_nxt;
  logic [IDX_W-1:0] r_vec_idx;
  logic [SC_W-1:0]  r_settle_cnt;
  logic             r_dut_a;
  logic [IDX_W-1:0] r_first_err_idx;

  logic w_start_acc;
  logic w_advance;
  logic w_err_inc;
  logic w_mismatch;
  logic w_last_vec;
  logic w_stop;

  // dut_y comes straight from a combinational gate on this clock, so no synchroniser.
  assign w_mismatch = (dut_y == r_dut_a);
  assign w_last_vec = (r_vec_idx == LAST_IDX);

`ifdef BIST_ABORT_ON_ERR_EN
  assign w_stop = w_last_vec | w_mismatch;
`else
  assign w_stop = w_last_vec;
`endif

  // State register; reset discards any run in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and per-cycle control strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_start_acc = 1'b0;
    w_advance   = 1'b0;
    w_err_inc   = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_start_acc = 1'b1;
          w_state_nxt = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (r_settle_cnt == SETTLE_LAST) w_state_nxt = ST_CHECK;
      end
      ST_CHECK: begin
        w_err_inc = w_mismatch;
        if (w_stop) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_advance   = 1'b1;
          w_state_nxt = ST_SETTLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Stimulus, vector index, settle timer and first-failure capture.
  always_ff @(posedge clk) begin
    if (rst || w_start_acc) begin
      r_vec_idx       <= '0;
      r_settle_cnt    <= '0;
      r_dut_a         <= 1'b0;
      r_first_err_idx <= NONE_IDX;
    end else begin
      if (r_state == ST_SETTLE) begin
        r_settle_cnt <= r_settle_cnt + SC_W'(1);
      end
      if (r_state == ST_CHECK && w_mismatch && r_first_err_idx == NONE_IDX) begin
        r_first_err_idx <= r_vec_idx;
      end
      if (w_advance) begin
        r_vec_idx    <= r_vec_idx + IDX_W'(1);
        r_dut_a      <= ~r_dut_a;
        r_settle_cnt <= '0;
      end
    end
  end

  bist_sat_counter #(
    .CNT_W (CNT_W)
  ) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_start_acc),
    .i_inc (w_err_inc),
    .o_cnt (err_count)
  );

  assign dut_a         = r_dut_a;
  assign busy          = (r_state == ST_SETTLE) || (r_state == ST_CHECK);
  assign done          = (r_state == ST_DONE);
  assign pass          = done && (err_count == '0);
  assign first_err_idx = r_first_err_idx;

endmodule

// File: tb/tb_not_gate_bist.sv
// Directed bench for not_gate_bist: gate models, timing, restart/reset handling.
// Latency checks count clock edges from the start-accepting edge to done.
// Expectations adapt to BIST_ABORT_ON_ERR_EN when it is defined.
module tb_not_gate_bist;

`ifdef BIST_ABORT_ON_ERR_EN
  localparam bit ABORT = 1'b1;
`else
  localparam bit ABORT = 1'b0;
`endif

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       start = 1'b0;
  logic       dut_a, dut_y, busy, done, pass;
  logic [7:0] err_count;
  logic [2:0] first_err_idx;

  logic       start2 = 1'b0;
  logic       dut_a2, dut_y2, busy2, done2, pass2;
  logic [7:0] err_count2;
  logic [1:0] first_err_idx2;

  // 0: NOT, 1: buffer, 2: stuck-1, 3: stuck-0, 4: NOT until fault, then buffer
  int   mode  = 0;
  logic fault = 1'b0;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  // Gate-under-test models.
  always_comb begin
    dut_y = ~dut_a;
    case (mode)
      1:       dut_y = dut_a;
      2:       dut_y = 1'b1;
      3:       dut_y = 1'b0;
      4:       dut_y = fault ? dut_a : ~dut_a;
      default: dut_y = ~dut_a;
    endcase
  end

  assign dut_y2 = ~dut_a2;

  not_gate_bist u_dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .dut_a         (dut_a),
    .dut_y         (dut_y),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .err_count     (err_count),
    .first_err_idx (first_err_idx)
  );

  not_gate_bist #(
    .NUM_VECTORS (4),
    .SETTLE_CYC  (3),
    .CNT_W       (8)
  ) u_dut2 (
    .clk           (clk),
    .rst           (rst),
    .start         (start2),
    .dut_a         (dut_a2),
    .dut_y         (dut_y2),
    .busy          (busy2),
    .done          (done2),
    .pass          (pass2),
    .err_count     (err_count2),
    .first_err_idx (first_err_idx2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound, output int n);
    n = 0;
    while (!done && n < bound) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b want 0", done); end
    tests_run++; if (pass !== 1'b0) begin tests_failed++; $display("FAIL reset_pass: got %b want 0", pass); end
    tests_run++; if (err_count !== 8'd0) begin tests_failed++; $display("FAIL reset_err: got %0d want 0", err_count); end
    tests_run++; if (first_err_idx !== 3'b111) begin tests_failed++; $display("FAIL reset_fei: got %0d want 7", first_err_idx); end
    tests_run++; if (dut_a !== 1'b0) begin tests_failed++; $display("FAIL reset_dut_a: got %b want 0", dut_a); end
    tests_run++; if (first_err_idx2 !== 2'b11) begin tests_failed++; $display("FAIL reset_fei2: got %0d want 3", first_err_idx2); end
  endtask

  task automatic test_not_model();
    int n;
    mode = 0;
    pulse_start();
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL not_busy: got %b want 1", busy); end
    wait_done(40, n);
    tests_run++; if (n !== 16) begin tests_failed++; $display("FAIL not_latency: got %0d want 16", n); end
    tests_run++; if (pass !== 1'b1) begin tests_failed++; $display("FAIL not_pass: got %b want 1", pass); end
    tests_run++; if (err_count !== 8'd0) begin tests_failed++; $display("FAIL not_err: got %0d want 0", err_count); end
    tests_run++; if (first_err_idx !== 3'd7) begin tests_failed++; $display("FAIL not_fei: got %0d want 7", first_err_idx); end
    tests_run++; if (dut_a !== 1'b1) begin tests_failed++; $display("FAIL not_dut_a: got %b want 1", dut_a); end
  endtask

  task automatic test_buffer();
    int n;
    mode = 1;
    pulse_start();
    wait_done(40, n);
    tests_run++; if (n !== (ABORT ? 2 : 16)) begin tests_failed++; $display("FAIL buf_latency: got %0d want %0d", n, ABORT ? 2 : 16); end
    tests_run++; if (err_count !== (ABORT ? 8'd1 : 8'd8)) begin tests_failed++; $display("FAIL buf_err: got %0d want %0d", err_count, ABORT ? 1 : 8); end
    tests_run++; if (first_err_idx !== 3'd0) begin tests_failed++; $display("FAIL buf_fei: got %0d want 0", first_err_idx); end
    tests_run++; if (pass !== 1'b0) begin tests_failed++; $display("FAIL buf_pass: got %b want 0", pass); end
    tests_run++; if (dut_a !== (ABORT ? 1'b0 : 1'b1)) begin tests_failed++; $display("FAIL buf_dut_a: got %b want %b", dut_a, !ABORT); end
    tick();
    tick();
    tests_run++; if (done !== 1'b1) begin tests_failed++; $display("FAIL buf_done_hold: got %b want 1", done); end
    tests_run++; if (err_count !== (ABORT ? 8'd1 : 8'd8)) begin tests_failed++; $display("FAIL buf_err_hold: got %0d want %0d", err_count, ABORT ? 1 : 8); end
  endtask

  task automatic test_stuck1();
    int n;
    mode = 2;
    pulse_start();
    wait_done(40, n);
    tests_run++; if (n !== (ABORT ? 4 : 16)) begin tests_failed++; $display("FAIL s1_latency: got %0d want %0d", n, ABORT ? 4 : 16); end
    tests_run++; if (err_count !== (ABORT ? 8'd1 : 8'd4)) begin tests_failed++; $display("FAIL s1_err: got %0d want %0d", err_count, ABORT ? 1 : 4); end
    tests_run++; if (first_err_idx !== 3'd1) begin tests_failed++; $display("FAIL s1_fei: got %0d want 1", first_err_idx); end
    tests_run++; if (pass !== 1'b0) begin tests_failed++; $display("FAIL s1_pass: got %b want 0", pass); end
  endtask

  task automatic test_stuck0();
    int n;
    mode = 3;
    pulse_start();
    wait_done(40, n);
    tests_run++; if (n !== (ABORT ? 2 : 16)) begin tests_failed++; $display("FAIL s0_latency: got %0d want %0d", n, ABORT ? 2 : 16); end
    tests_run++; if (err_count !== (ABORT ? 8'd1 : 8'd4)) begin tests_failed++; $display("FAIL s0_err: got %0d want %0d", err_count, ABORT ? 1 : 4); end
    tests_run++; if (first_err_idx !== 3'd0) begin tests_failed++; $display("FAIL s0_fei: got %0d want 0", first_err_idx); end
  endtask

  // Only the last vector fails: first_err_idx is 7 like "none", pass tells them apart.
  task automatic test_last_vec_collision();
    int n;
    mode  = 4;
    fault = 1'b0;
    pulse_start();
    repeat (14) tick();
    fault = 1'b1;
    wait_done(40, n);
    fault = 1'b0;
    tests_run++; if (n + 14 !== 16) begin tests_failed++; $display("FAIL col_latency: got %0d want 16", n + 14); end
    tests_run++; if (err_count !== 8'd1) begin tests_failed++; $display("FAIL col_err: got %0d want 1", err_count); end
    tests_run++; if (first_err_idx !== 3'd7) begin tests_failed++; $display("FAIL col_fei: got %0d want 7", first_err_idx); end
    tests_run++; if (pass !== 1'b0) begin tests_failed++; $display("FAIL col_pass: got %b want 0", pass); end
  endtask

  task automatic test_restart_ignored();
    int n;
    mode = 0;
    pulse_start();
    repeat (3) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(40, n);
    tests_run++; if (n + 4 !== 16) begin tests_failed++; $display("FAIL restart_latency: got %0d want 16", n + 4); end
    tests_run++; if (pass !== 1'b1) begin tests_failed++; $display("FAIL restart_pass: got %b want 1", pass); end
  endtask

  task automatic test_midrun_reset();
    int n;
    mode = 1;
    pulse_start();
    repeat (9) tick();
    tests_run++; if (err_count !== (ABORT ? 8'd1 : 8'd4)) begin tests_failed++; $display("FAIL mid_err_pre: got %0d want %0d", err_count, ABORT ? 1 : 4); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL mid_busy: got %b want 0", busy); end
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL mid_done: got %b want 0", done); end
    tests_run++; if (err_count !== 8'd0) begin tests_failed++; $display("FAIL mid_err: got %0d want 0", err_count); end
    tests_run++; if (first_err_idx !== 3'd7) begin tests_failed++; $display("FAIL mid_fei: got %0d want 7", first_err_idx); end
    tests_run++; if (dut_a !== 1'b0) begin tests_failed++; $display("FAIL mid_dut_a: got %b want 0", dut_a); end
    tick();
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL mid_idle: got %b want 0", busy); end
    mode = 0;
    pulse_start();
    wait_done(40, n);
    tests_run++; if (n !== 16) begin tests_failed++; $display("FAIL mid_rerun_latency: got %0d want 16", n); end
    tests_run++; if (pass !== 1'b1) begin tests_failed++; $display("FAIL mid_rerun_pass: got %b want 1", pass); end
  endtask

  task automatic test_rst_beats_start();
    start = 1'b1;
    rst   = 1'b1;
    tick();
    start = 1'b0;
    rst   = 1'b0;
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rst_win_busy: got %b want 0", busy); end
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL rst_win_done: got %b want 0", done); end
  endtask

  // Four vectors, three settle cycles: dut_a may only move after edges 4, 8 and 12.
  task automatic test_long_settle();
    int          n;
    logic        prev;
    logic [31:0] change_mask;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    tests_run++; if (dut_a2 !== 1'b0) begin tests_failed++; $display("FAIL ls_dut_a0: got %b want 0", dut_a2); end
    prev        = dut_a2;
    change_mask = '0;
    n           = 0;
    while (!done2 && n < 31) begin
      tick();
      n++;
      if (dut_a2 !== prev) change_mask[n] = 1'b1;
      prev = dut_a2;
    end
    tests_run++; if (n !== 16) begin tests_failed++; $display("FAIL ls_latency: got %0d want 16", n); end
    tests_run++; if (change_mask !== 32'h0000_1110) begin tests_failed++; $display("FAIL ls_toggle_cycles: got %h want 00001110", change_mask); end
    tests_run++; if (pass2 !== 1'b1) begin tests_failed++; $display("FAIL ls_pass: got %b want 1", pass2); end
    tests_run++; if (err_count2 !== 8'd0) begin tests_failed++; $display("FAIL ls_err: got %0d want 0", err_count2); end
    tests_run++; if (first_err_idx2 !== 2'd3) begin tests_failed++; $display("FAIL ls_fei: got %0d want 3", first_err_idx2); end
  endtask

  initial begin
    test_reset();
    test_not_model();
    test_buffer();
    test_stuck1();
    test_stuck0();
    test_last_vec_collision();
    test_restart_ignored();
    test_midrun_reset();
    test_rst_beats_start();
    test_long_settle();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/not_gate_bist.md
Name: not_gate_bist

Overview:
On-chip built-in self-test (BIST) engine for the NOT gate. It is the checking end of the gate's stimulus/response interface.
- Drives a toggling stimulus onto the gate input.
- Waits a programmable settle time, then samples the gate output and compares it with the expected inverted value.
- Counts mismatches and reports pass/fail.
- Sits beside the gate under test; software or a top-level FSM pulses start and reads the result.

Parameters:
- NUM_VECTORS, 8: number of stimulus vectors applied per run (>=1).
- SETTLE_CYC, 1: clock cycles dut_a is held before dut_y is sampled (>=1).
- CNT_W, 8: width of err_count; the counter saturates at 2^CNT_W-1.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  begin a run; sampled in IDLE or DONE only.
- dut_a  out  1  stimulus to the gate input.
- dut_y  in  1  gate output; assumed to settle within SETTLE_CYC cycles.
- busy  out  1  high while a run is in progress.
- done  out  1  level; high from run completion until the next accepted start or rst.
- pass  out  1  valid while done=1; 1 when err_count==0.
- err_count  out  CNT_W  number of mismatching vectors in the last run.
- first_err_idx  out  IDX_W  index of the first mismatching vector; all-ones if none. IDX_W = max(1, $clog2(NUM_VECTORS)).

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE, dut_a=0, busy=0, done=0, pass=0, err_count=0, first_err_idx=all-ones.
  - Internal vec_idx=0 and settle counter=0.
  - Reset takes effect mid-run and the run is discarded.
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE / DONE, start=1:
  - Next state SETTLE; busy=1, done=0, pass=0.
  - err_count=0, first_err_idx=all-ones, vec_idx=0, dut_a=0, settle counter=0.
- SETTLE:
  - Settle counter increments each cycle.
  - When it reaches SETTLE_CYC-1, next state is CHECK.
  - dut_a is stable throughout.
- CHECK, one cycle:
  - Mismatch when dut_y != ~dut_a.
  - On mismatch: err_count increments, saturating. If first_err_idx is all-ones, it takes vec_idx.
  - If vec_idx==NUM_VECTORS-1: next state DONE; busy=0, done=1, pass=(final err_count==0), including the current vector's result.
  - Otherwise: vec_idx+1, dut_a toggles, settle counter clears, next state SETTLE.
- Stimulus sequence is 0,1,0,1,…: vector k drives dut_a = k[0].
- Latency: done rises exactly NUM_VECTORS*(SETTLE_CYC+1) cycles after the edge that accepts start.
- start while busy is ignored and has no effect on the run.
- start and rst in the same cycle: rst wins.
- In DONE, dut_a holds its last value; results hold until the next start.
- first_err_idx all-ones collides with a legal index only when NUM_VECTORS is a power of two. In that case pass distinguishes the two meanings, and the bench must check both.
- dut_y is sampled directly. It comes from a combinational gate on the same clock, so no synchroniser is used.

Optional Feature:
BIST_ABORT_ON_ERR_EN
- Defined: the first mismatch in CHECK moves straight to DONE. err_count=1, pass=0, first_err_idx=that vector's index; the remaining vectors are not applied.
- Undefined: all NUM_VECTORS vectors are always applied and every mismatch is counted.

Decomposition:
- Package not_gate_bist_pkg holds:
  - the state enum (IDLE, SETTLE, CHECK, DONE) and state-width constant;
  - the helper function that computes IDX_W;
  - the NO_ERR_IDX all-ones constant.
- One sub-module, bist_sat_counter:
  - CNT_W-wide saturating up-counter with synchronous clear and increment enable;
  - used for err_count.
- Settle counter and vector index stay inline.

Test Plan:
- Correct NOT model (dut_y=~dut_a), defaults, start pulse at cycle 5 -> busy for 16 cycles, then done=1, pass=1, err_count=0, first_err_idx=7 (all-ones, 3 bits).
- Buffer model (dut_y=dut_a), defaults -> done after 16 cycles, err_count=8, pass=0, first_err_idx=0.
- Stuck-at-1 output (dut_y=1), defaults -> mismatches at vectors 1,3,5,7; err_count=4, first_err_idx=1, pass=0.
- Correct model, start re-pulsed at cycle 4 of a run, then rst asserted at cycle 10 -> the re-pulse has no effect. rst gives all outputs their reset values the next cycle. A new start afterwards gives done 16 cycles later with pass=1.
- SETTLE_CYC=3, NUM_VECTORS=4, correct model -> done exactly 16 cycles after start. dut_a changes only on the cycle after each CHECK.
- BIST_ABORT_ON_ERR_EN defined, buffer model, defaults -> done 2 cycles after start, err_count=1, first_err_idx=0, pass=0, dut_a still 0.
